// File: rtl/switch_pkg.sv
// Shared definitions for the key/switch input-conditioning stages.
// Holds the debounce FSM state encoding and the default settle time.
package switch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    // 10 ms at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage : switch_pkg

// File: rtl/switch_debounce_sync_chain.sv
// Per-bit flop pipeline that brings asynchronous inputs into the clk domain.
// There is no logic between stages, so each bit is an independent synchroniser.
module sync_chain #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [STAGES];

    // NOTE: the whole chain is reset so no stale switch value survives rst;
    // the array is only STAGES entries deep, so a reset loop is cheap here.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep this a true shift register;
            // blocking ones would collapse every stage into a single flop.
            stages[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[STAGES-1];

endmodule : sync_chain

// File: rtl/switch_debounce.sv
// Synchronises and debounces a slide-switch vector as a whole, presenting a
// glitch-free value, a one-cycle changed strobe and a settling status flag.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic             hold,
    output logic [WIDTH-1:0] a_stable,
    output logic             changed,
    output logic             settling
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cand     <= '0;
            cnt      <= '0;
            a_stable <= '0;
            changed  <= 1'b0;
            settling <= 1'b0;
        end else begin
            changed <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync != a_stable) begin
                        cand     <= sync;
                        cnt      <= '0;
                        state    <= SETTLING;
                        settling <= 1'b1;
                    end
                end
                SETTLING: begin
                    // A change on sync restarts the settle, even on the terminal count.
                    if (sync != cand) begin
                        cand <= sync;
                        cnt  <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else if (!hold) begin
                        state    <= COMMIT;
                        settling <= 1'b0;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (cand != a_stable) begin
                        a_stable <= cand;
                        changed  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    settling <= 1'b0;
                end
            endcase
        end
    end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Directed self-checking bench for switch_debounce with a short settle time.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_switch_debounce;
    import switch_pkg::*;

    localparam int WIDTH           = 8;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sw;
    logic             hold;
    logic [WIDTH-1:0] a_stable;
    logic             changed;
    logic             settling;

    int checks = 0;
    int errors = 0;

    switch_debounce #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .hold     (hold),
        .a_stable (a_stable),
        .changed  (changed),
        .settling (settling)
    );

    always #5 clk = ~clk;

    // Advance one clock and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        sw   = 8'hFF;
        hold = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        checks++;
        if (a_stable !== 8'h00) begin
            errors++;
            $display("FAIL reset_a_stable: got %h expected 00", a_stable);
        end
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_changed: got %b expected 0", changed);
        end
        checks++;
        if (settling !== 1'b0) begin
            errors++;
            $display("FAIL reset_settling: got %b expected 0", settling);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        rst = 1'b0;
        sw  = 8'h00;
        repeat (4) tick();
        checks++;
        if (a_stable !== 8'h00 || settling !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: a_stable %h settling %b expected 00/0", a_stable, settling);
        end
    endtask

    task automatic test_clean_edge();
        logic [WIDTH-1:0] exp_a;
        sw = 8'h35;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_a = (c >= 7) ? 8'h35 : 8'h00;
            checks++;
            if (a_stable !== exp_a) begin
                errors++;
                $display("FAIL clean_a_stable c%0d: got %h expected %h", c, a_stable, exp_a);
            end
            checks++;
            if (changed !== (c == 7)) begin
                errors++;
                $display("FAIL clean_changed c%0d: got %b expected %b", c, changed, (c == 7));
            end
            checks++;
            if (settling !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL clean_settling c%0d: got %b expected %b", c, settling, (c >= 2 && c <= 5));
            end
        end
    endtask

    task automatic test_bounce();
        logic [WIDTH-1:0] exp_a;
        for (int i = 0; i < 6; i++) begin
            sw = (i % 2 == 0) ? 8'h34 : 8'h35;
            tick();
            checks++;
            if (a_stable !== 8'h35 || changed !== 1'b0) begin
                errors++;
                $display("FAIL bounce_toggle i%0d: a_stable %h changed %b expected 35/0", i, a_stable, changed);
            end
        end
        sw = 8'h34;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_a = (c >= 7) ? 8'h34 : 8'h35;
            checks++;
            if (a_stable !== exp_a) begin
                errors++;
                $display("FAIL bounce_a_stable c%0d: got %h expected %h", c, a_stable, exp_a);
            end
            checks++;
            if (changed !== (c == 7)) begin
                errors++;
                $display("FAIL bounce_changed c%0d: got %b expected %b", c, changed, (c == 7));
            end
        end
    endtask

    task automatic test_glitch_back();
        for (int c = 0; c < 12; c++) begin
            sw = (c == 0) ? 8'h44 : 8'h34;
            tick();
            checks++;
            if (a_stable !== 8'h34 || changed !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold_value c%0d: a_stable %h changed %b expected 34/0", c, a_stable, changed);
            end
            checks++;
            if (settling !== (c >= 2 && c <= 6)) begin
                errors++;
                $display("FAIL glitch_settling c%0d: got %b expected %b", c, settling, (c >= 2 && c <= 6));
            end
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE);
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        sw   = 8'hA5;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (a_stable !== 8'h34 || changed !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen c%0d: a_stable %h changed %b expected 34/0", c, a_stable, changed);
            end
            checks++;
            if (settling !== (c >= 2)) begin
                errors++;
                $display("FAIL hold_settling c%0d: got %b expected %b", c, settling, (c >= 2));
            end
        end
        hold = 1'b0;
        tick();
        checks++;
        if (a_stable !== 8'h34 || changed !== 1'b0 || settling !== 1'b0) begin
            errors++;
            $display("FAIL hold_commit_cycle: a_stable %h changed %b settling %b expected 34/0/0", a_stable, changed, settling);
        end
        tick();
        checks++;
        if (a_stable !== 8'hA5 || changed !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: a_stable %h changed %b expected a5/1", a_stable, changed);
        end
        tick();
        checks++;
        if (a_stable !== 8'hA5 || changed !== 1'b0) begin
            errors++;
            $display("FAIL hold_single_pulse: a_stable %h changed %b expected a5/0", a_stable, changed);
        end
    endtask

    task automatic test_reset_mid_settle();
        logic [WIDTH-1:0] exp_a;
        sw = 8'h5A;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (a_stable !== 8'hA5 || settling !== (c >= 2)) begin
                errors++;
                $display("FAIL midreset_pre c%0d: a_stable %h settling %b expected a5/%b", c, a_stable, settling, (c >= 2));
            end
        end
        checks++;
        if (dut.cnt !== 2'd2) begin
            errors++;
            $display("FAIL midreset_count: got %0d expected 2", dut.cnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (a_stable !== 8'h00 || changed !== 1'b0 || settling !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: a_stable %h changed %b settling %b expected 00/0/0", a_stable, changed, settling);
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_a = (c >= 7) ? 8'h5A : 8'h00;
            checks++;
            if (a_stable !== exp_a) begin
                errors++;
                $display("FAIL midreset_a_stable c%0d: got %h expected %h", c, a_stable, exp_a);
            end
            checks++;
            if (changed !== (c == 7)) begin
                errors++;
                $display("FAIL midreset_changed c%0d: got %b expected %b", c, changed, (c == 7));
            end
            checks++;
            if (settling !== (c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL midreset_settling c%0d: got %b expected %b", c, settling, (c >= 2 && c <= 5));
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        sw   = '0;
        hold = 1'b0;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_glitch_back();
        test_hold();
        test_reset_mid_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce
